// File: rtl/dcache_dp.sv
// Dual-port direct-mapped write-through / no-write-allocate data cache.
// Port 0 serves tagged loads, port 1 serves stores; one outstanding load miss at a time.
module dcache_dp #(
    parameter int NUM_LINES    = 32,
    parameter int NUM_BANKS    = 2,
    parameter int LQ_SIZE      = 16,
    parameter int LQ_IDX_WIDTH = $clog2(LQ_SIZE)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [31:0]             Dcache_addr_0,
    input  logic [1:0]              Dcache_command_0,
    input  logic [1:0]              Dcache_size_0,
    input  logic [LQ_IDX_WIDTH-1:0] Dcache_req_tag,
    output logic                    Dcache_req_0_accept,
    output logic [63:0]             Dcache_data_out_0,
    output logic                    Dcache_valid_out_0,
    output logic [LQ_IDX_WIDTH-1:0] Dcache_load_tag,
    input  logic [31:0]             Dcache_addr_1,
    input  logic [1:0]              Dcache_command_1,
    input  logic [1:0]              Dcache_size_1,
    input  logic [63:0]             Dcache_store_data_1,
    output logic                    Dcache_req_1_accept,
    output logic [63:0]             Dcache_data_out_1,
    output logic                    Dcache_valid_out_1,
    output logic [1:0]              proc2mem_command,
    output logic [31:0]             proc2mem_addr,
    output logic [63:0]             proc2mem_data,
    output logic [1:0]              proc2mem_size,
    input  logic [3:0]              mem2proc_transaction_tag,
    input  logic [63:0]             mem2proc_data,
    input  logic [3:0]              mem2proc_data_tag
);

    localparam logic [1:0] MEM_NONE  = 2'd0;
    localparam logic [1:0] MEM_LOAD  = 2'd1;
    localparam logic [1:0] MEM_STORE = 2'd2;
    localparam logic [1:0] SZ_DOUBLE = 2'd3;
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = 29 - IDX_W;
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_REQ  = 2'd1,
        MISS_WAIT = 2'd2
    } state_t;

    state_t                  state_r, next_state_s;
    logic [NUM_LINES-1:0]    valid_r;
    logic [TAG_W-1:0]        tag_r  [NUM_LINES];
    logic [63:0]             data_r [NUM_LINES];
    logic [28:0]             miss_blk_r;
    logic [LQ_IDX_WIDTH-1:0] miss_lq_tag_r;
    logic [3:0]              mem_id_r;
    logic                    resp_valid_r;
    logic [63:0]             resp_data_r;
    logic [LQ_IDX_WIDTH-1:0] resp_tag_r;

    logic [IDX_W-1:0] ld_idx_s, st_idx_s, miss_idx_s;
    logic [TAG_W-1:0] ld_tag_s, st_tag_s, miss_tag_s;
    logic             ld_hit_s, st_hit_s, same_bank_s, fill_s;
    logic             ld_accept_s, st_pending_s, st_accept_s;
    logic [1:0]       mem_cmd_s, mem_size_s;
    logic [31:0]      mem_addr_s;
    logic [63:0]      mem_data_s;
    logic             unused_s;

    // Merge right-aligned store bytes into a line at the given byte offset.
    function automatic logic [63:0] merge_bytes(input logic [63:0] line, input logic [63:0] wdata,
                                                input logic [2:0] off, input logic [1:0] size);
        logic [63:0] result;
        int          nbytes;
        int          j;
        result = line;
        case (size)
            2'd0:    nbytes = 1;
            2'd1:    nbytes = 2;
            2'd2:    nbytes = 4;
            default: nbytes = 8;
        endcase
        for (int i = 0; i < 8; i++) begin
            j = i - int'(off);
            if ((j >= 0) && (j < nbytes)) begin
                result[8*i +: 8] = wdata[8*j +: 8];
            end
        end
        return result;
    endfunction

    assign ld_idx_s   = Dcache_addr_0[3 +: IDX_W];
    assign ld_tag_s   = Dcache_addr_0[31 -: TAG_W];
    assign st_idx_s   = Dcache_addr_1[3 +: IDX_W];
    assign st_tag_s   = Dcache_addr_1[31 -: TAG_W];
    assign miss_idx_s = miss_blk_r[IDX_W-1:0];
    assign miss_tag_s = miss_blk_r[28 -: TAG_W];
    assign ld_hit_s   = valid_r[ld_idx_s] && (tag_r[ld_idx_s] == ld_tag_s);
    assign st_hit_s   = valid_r[st_idx_s] && (tag_r[st_idx_s] == st_tag_s);
    assign same_bank_s = (NUM_BANKS == 1) ? 1'b1
                       : (Dcache_addr_0[3 +: BANK_W] == Dcache_addr_1[3 +: BANK_W]);
    // mem_id_r is cleared on reset, so a stray data tag after an aborted miss never matches.
    assign fill_s = (state_r == MISS_WAIT) && (mem_id_r != 4'd0) && (mem2proc_data_tag == mem_id_r);
    assign unused_s = ^{Dcache_size_0, Dcache_addr_0[2:0]};

    // Next-state logic, request acceptance and memory-port arbitration (fill before store).
    always_comb begin
        next_state_s = state_r;
        ld_accept_s  = (Dcache_command_0 == MEM_LOAD) && (state_r == IDLE);
        st_pending_s = (Dcache_command_1 == MEM_STORE)
                    && !(ld_accept_s && same_bank_s)
                    && !((state_r == MISS_WAIT) && (Dcache_addr_1[31:3] == miss_blk_r));
        st_accept_s  = 1'b0;
        mem_cmd_s    = MEM_NONE;
        mem_addr_s   = 32'd0;
        mem_data_s   = 64'd0;
        mem_size_s   = 2'd0;
        if (state_r == MISS_REQ) begin
            mem_cmd_s  = MEM_LOAD;
            mem_addr_s = {miss_blk_r, 3'b000};
            mem_size_s = SZ_DOUBLE;
        end else if (st_pending_s) begin
            mem_cmd_s   = MEM_STORE;
            mem_addr_s  = Dcache_addr_1;
            mem_data_s  = Dcache_store_data_1;
            mem_size_s  = Dcache_size_1;
            st_accept_s = (mem2proc_transaction_tag != 4'd0);
        end else begin
            mem_cmd_s = MEM_NONE;
        end
        case (state_r)
            IDLE: begin
                if (ld_accept_s && !ld_hit_s) begin
                    next_state_s = MISS_REQ;
                end else begin
                    next_state_s = IDLE;
                end
            end
            MISS_REQ: begin
                if (mem2proc_transaction_tag != 4'd0) begin
                    next_state_s = MISS_WAIT;
                end else begin
                    next_state_s = MISS_REQ;
                end
            end
            MISS_WAIT: begin
                if (fill_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = MISS_WAIT;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // FSM state, miss bookkeeping and the registered load response.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r       <= IDLE;
            miss_blk_r    <= 29'd0;
            miss_lq_tag_r <= '0;
            mem_id_r      <= 4'd0;
            resp_valid_r  <= 1'b0;
            resp_data_r   <= 64'd0;
            resp_tag_r    <= '0;
        end else begin
            state_r      <= next_state_s;
            resp_valid_r <= 1'b0;
            if (ld_accept_s && ld_hit_s) begin
                resp_valid_r <= 1'b1;
                resp_data_r  <= data_r[ld_idx_s];
                resp_tag_r   <= Dcache_req_tag;
            end else if (ld_accept_s) begin
                miss_blk_r    <= Dcache_addr_0[31:3];
                miss_lq_tag_r <= Dcache_req_tag;
            end
            if ((state_r == MISS_REQ) && (mem2proc_transaction_tag != 4'd0)) begin
                mem_id_r <= mem2proc_transaction_tag;
            end
            if (fill_s) begin
                resp_valid_r <= 1'b1;
                resp_data_r  <= mem2proc_data;
                resp_tag_r   <= miss_lq_tag_r;
                mem_id_r     <= 4'd0;
            end
        end
    end

    // Line storage: store-hit byte merge, then the fill (which owns its line that cycle).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_r <= '0;
            for (int i = 0; i < NUM_LINES; i++) begin
                tag_r[i]  <= '0;
                data_r[i] <= 64'd0;
            end
        end else begin
            if (st_accept_s && st_hit_s) begin
                data_r[st_idx_s] <= merge_bytes(data_r[st_idx_s], Dcache_store_data_1,
                                                Dcache_addr_1[2:0], Dcache_size_1);
            end
            if (fill_s) begin
                valid_r[miss_idx_s] <= 1'b1;
                tag_r[miss_idx_s]   <= miss_tag_s;
                data_r[miss_idx_s]  <= mem2proc_data;
            end
        end
    end

    assign Dcache_req_0_accept = ld_accept_s;
    assign Dcache_req_1_accept = st_accept_s;
    assign Dcache_valid_out_0  = resp_valid_r;
    assign Dcache_data_out_0   = resp_data_r;
    assign Dcache_load_tag     = resp_tag_r;
    assign Dcache_data_out_1   = 64'd0;
    assign Dcache_valid_out_1  = 1'b0;
    assign proc2mem_command    = mem_cmd_s;
    assign proc2mem_addr       = mem_addr_s;
    assign proc2mem_data       = mem_data_s;
    assign proc2mem_size       = mem_size_s;

endmodule

// File: tb/tb_dcache_dp.sv
// Directed bench for dcache_dp: the bench plays the LSQ and the memory with hand-computed expectations.
module tb_dcache_dp;

    logic        clock;
    logic        reset;
    logic [31:0] Dcache_addr_0;
    logic [1:0]  Dcache_command_0;
    logic [1:0]  Dcache_size_0;
    logic [3:0]  Dcache_req_tag;
    logic        Dcache_req_0_accept;
    logic [63:0] Dcache_data_out_0;
    logic        Dcache_valid_out_0;
    logic [3:0]  Dcache_load_tag;
    logic [31:0] Dcache_addr_1;
    logic [1:0]  Dcache_command_1;
    logic [1:0]  Dcache_size_1;
    logic [63:0] Dcache_store_data_1;
    logic        Dcache_req_1_accept;
    logic [63:0] Dcache_data_out_1;
    logic        Dcache_valid_out_1;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [1:0]  proc2mem_size;
    logic [3:0]  mem2proc_transaction_tag;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_data_tag;

    int n_checks = 0;
    int n_fail   = 0;

    dcache_dp dut (
        .clock(clock), .reset(reset),
        .Dcache_addr_0(Dcache_addr_0), .Dcache_command_0(Dcache_command_0),
        .Dcache_size_0(Dcache_size_0), .Dcache_req_tag(Dcache_req_tag),
        .Dcache_req_0_accept(Dcache_req_0_accept), .Dcache_data_out_0(Dcache_data_out_0),
        .Dcache_valid_out_0(Dcache_valid_out_0), .Dcache_load_tag(Dcache_load_tag),
        .Dcache_addr_1(Dcache_addr_1), .Dcache_command_1(Dcache_command_1),
        .Dcache_size_1(Dcache_size_1), .Dcache_store_data_1(Dcache_store_data_1),
        .Dcache_req_1_accept(Dcache_req_1_accept), .Dcache_data_out_1(Dcache_data_out_1),
        .Dcache_valid_out_1(Dcache_valid_out_1),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data), .proc2mem_size(proc2mem_size),
        .mem2proc_transaction_tag(mem2proc_transaction_tag),
        .mem2proc_data(mem2proc_data), .mem2proc_data_tag(mem2proc_data_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        Dcache_command_0         = 2'd0;
        Dcache_command_1         = 2'd0;
        mem2proc_transaction_tag = 4'd0;
        mem2proc_data_tag        = 4'd0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        Dcache_addr_0 = 32'd0; Dcache_size_0 = 2'd0; Dcache_req_tag = 4'd0;
        Dcache_addr_1 = 32'd0; Dcache_size_1 = 2'd0; Dcache_store_data_1 = 64'd0;
        mem2proc_data = 64'd0;
        idle_inputs();
        tick(); tick();
        check_eq("rst_valid0", Dcache_valid_out_0, 64'd0);
        check_eq("rst_data0", Dcache_data_out_0, 64'd0);
        check_eq("rst_ltag", Dcache_load_tag, 64'd0);
        check_eq("rst_memcmd", proc2mem_command, 64'd0);
        check_eq("rst_valid1", Dcache_valid_out_1, 64'd0);
        #3 reset = 1'b1;
        tick();

        // Cold miss to 0x100, memory id 5
        Dcache_command_0 = 2'd1; Dcache_addr_0 = 32'h100; Dcache_req_tag = 4'd3;
        settle();
        check_eq("cold_acc0", Dcache_req_0_accept, 64'd1);
        tick();
        idle_inputs();
        settle();
        check_eq("cold_memcmd", proc2mem_command, 64'd1);
        check_eq("cold_memaddr", proc2mem_addr, 64'h100);
        check_eq("cold_memsize", proc2mem_size, 64'd3);
        mem2proc_transaction_tag = 4'd5;
        tick();
        mem2proc_transaction_tag = 4'd0;
        check_eq("cold_noresp", Dcache_valid_out_0, 64'd0);
        tick(); tick(); tick();
        mem2proc_data_tag = 4'd5; mem2proc_data = 64'hDEAD_BEEF_0000_0001;
        settle();
        check_eq("wait_memcmd", proc2mem_command, 64'd0);
        check_eq("wait_novalid", Dcache_valid_out_0, 64'd0);
        tick();
        mem2proc_data_tag = 4'd0;
        check_eq("fill_valid", Dcache_valid_out_0, 64'd1);
        check_eq("fill_data", Dcache_data_out_0, 64'hDEAD_BEEF_0000_0001);
        check_eq("fill_tag", Dcache_load_tag, 64'd3);
        tick();
        check_eq("fill_pulse", Dcache_valid_out_0, 64'd0);

        // Hit on the filled line
        Dcache_command_0 = 2'd1; Dcache_addr_0 = 32'h100; Dcache_req_tag = 4'd4;
        settle();
        check_eq("hit_acc0", Dcache_req_0_accept, 64'd1);
        check_eq("hit_nomem", proc2mem_command, 64'd0);
        tick();
        idle_inputs();
        settle();
        check_eq("hit_valid", Dcache_valid_out_0, 64'd1);
        check_eq("hit_data", Dcache_data_out_0, 64'hDEAD_BEEF_0000_0001);
        check_eq("hit_tag", Dcache_load_tag, 64'd4);
        check_eq("hit_nomem2", proc2mem_command, 64'd0);

        // Byte store to 0x103, first without memory acceptance
        Dcache_command_1 = 2'd2; Dcache_addr_1 = 32'h103; Dcache_size_1 = 2'd0;
        Dcache_store_data_1 = 64'hAA;
        settle();
        check_eq("st_noack_acc", Dcache_req_1_accept, 64'd0);
        check_eq("st_noack_cmd", proc2mem_command, 64'd2);
        mem2proc_transaction_tag = 4'd1;
        settle();
        check_eq("st_acc", Dcache_req_1_accept, 64'd1);
        check_eq("st_memaddr", proc2mem_addr, 64'h103);
        check_eq("st_memdata", proc2mem_data, 64'hAA);
        check_eq("st_memsize", proc2mem_size, 64'd0);
        tick();
        idle_inputs();
        Dcache_command_0 = 2'd1; Dcache_addr_0 = 32'h100; Dcache_req_tag = 4'd6;
        tick();
        idle_inputs();
        check_eq("merge_valid", Dcache_valid_out_0, 64'd1);
        check_eq("merge_data", Dcache_data_out_0, 64'hDEAD_BEEF_AA00_0001);

        // Bank conflict: load 0x100 with store 0x140 (both bank 0)
        Dcache_command_0 = 2'd1; Dcache_addr_0 = 32'h100; Dcache_req_tag = 4'd7;
        Dcache_command_1 = 2'd2; Dcache_addr_1 = 32'h140; Dcache_size_1 = 2'd3;
        Dcache_store_data_1 = 64'h1111_2222_3333_4444;
        mem2proc_transaction_tag = 4'd2;
        settle();
        check_eq("conf_acc0", Dcache_req_0_accept, 64'd1);
        check_eq("conf_acc1", Dcache_req_1_accept, 64'd0);
        Dcache_addr_1 = 32'h108;
        settle();
        check_eq("nconf_acc0", Dcache_req_0_accept, 64'd1);
        check_eq("nconf_acc1", Dcache_req_1_accept, 64'd1);
        tick();
        idle_inputs();
        check_eq("conf_ld_valid", Dcache_valid_out_0, 64'd1);
        check_eq("conf_ld_tag", Dcache_load_tag, 64'd7);

        // Miss to 0x200 with memory backpressure in MISS_REQ
        Dcache_command_0 = 2'd1; Dcache_addr_0 = 32'h200; Dcache_req_tag = 4'd9;
        settle();
        check_eq("m2_acc0", Dcache_req_0_accept, 64'd1);
        tick();
        Dcache_command_0 = 2'd1; Dcache_addr_0 = 32'h100;
        Dcache_command_1 = 2'd2; Dcache_addr_1 = 32'h308;
        for (int c = 0; c < 3; c++) begin
            settle();
            check_eq("bp_memcmd", proc2mem_command, 64'd1);
            check_eq("bp_memaddr", proc2mem_addr, 64'h200);
            check_eq("bp_acc0", Dcache_req_0_accept, 64'd0);
            check_eq("bp_acc1", Dcache_req_1_accept, 64'd0);
            tick();
        end
        mem2proc_transaction_tag = 4'd7;
        settle();
        check_eq("req_acc1", Dcache_req_1_accept, 64'd0);
        check_eq("req_memcmd", proc2mem_command, 64'd1);
        tick();

        // MISS_WAIT blocking
        mem2proc_transaction_tag = 4'd3;
        Dcache_addr_1 = 32'h200;
        settle();
        check_eq("mw_acc0", Dcache_req_0_accept, 64'd0);
        check_eq("mw_st_same", Dcache_req_1_accept, 64'd0);
        Dcache_addr_1 = 32'h308;
        settle();
        check_eq("mw_st_other", Dcache_req_1_accept, 64'd1);
        check_eq("mw_st_addr", proc2mem_addr, 64'h308);
        tick();
        idle_inputs();
        mem2proc_data_tag = 4'd4; mem2proc_data = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        mem2proc_data_tag = 4'd0;
        check_eq("wrongid_noresp", Dcache_valid_out_0, 64'd0);
        tick();
        check_eq("wrongid_noresp2", Dcache_valid_out_0, 64'd0);
        mem2proc_data_tag = 4'd7; mem2proc_data = 64'h0123_4567_89AB_CDEF;
        tick();
        mem2proc_data_tag = 4'd0;
        check_eq("m2_valid", Dcache_valid_out_0, 64'd1);
        check_eq("m2_data", Dcache_data_out_0, 64'h0123_4567_89AB_CDEF);
        check_eq("m2_tag", Dcache_load_tag, 64'd9);

        // Reset during MISS_WAIT for 0x300
        Dcache_command_0 = 2'd1; Dcache_addr_0 = 32'h300; Dcache_req_tag = 4'd2;
        tick();
        idle_inputs();
        mem2proc_transaction_tag = 4'd6;
        tick();
        mem2proc_transaction_tag = 4'd0;
        reset = 1'b0;
        settle();
        check_eq("mrst_memcmd", proc2mem_command, 64'd0);
        check_eq("mrst_valid", Dcache_valid_out_0, 64'd0);
        tick();
        #3 reset = 1'b1;
        tick();
        mem2proc_data_tag = 4'd6; mem2proc_data = 64'h5555_5555_5555_5555;
        tick();
        mem2proc_data_tag = 4'd0;
        check_eq("stray_noresp", Dcache_valid_out_0, 64'd0);
        Dcache_command_0 = 2'd1; Dcache_addr_0 = 32'h100; Dcache_req_tag = 4'd5;
        settle();
        check_eq("post_acc0", Dcache_req_0_accept, 64'd1);
        tick();
        idle_inputs();
        settle();
        check_eq("post_miss_valid", Dcache_valid_out_0, 64'd0);
        check_eq("post_miss_memcmd", proc2mem_command, 64'd1);
        check_eq("post_miss_addr", proc2mem_addr, 64'h100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
